// File: rtl/port_select_arbiter_if.sv
// Request/grant bundle between the requesting units and the port-select
// arbiter. The master side is the arbiter (drives grant/sel/busy/preempt);
// the slave side is the requester population (drives req).
interface port_select_arbiter_if;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       preempt;

    modport master (
        input  req,
        output grant,
        output sel,
        output busy,
        output preempt
    );

    modport slave (
        output req,
        input  grant,
        input  sel,
        input  busy,
        input  preempt
    );
endinterface

// File: rtl/port_select_arbiter.sv
// Round-robin owner of the 8-way port-select mux.
// An owner keeps the mux until it drops its request, or until it has held
// MAX_HOLD cycles while someone else is waiting. Every hand-off passes
// through a single grant-free GAP cycle so that sel only moves while grant
// is zero. All outputs come straight from flops.
module port_select_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    port_select_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam logic [7:0] MAX_HOLD_C = MAX_HOLD[7:0];

    // Round-robin pick: first set bit scanning upward from last+1, modulo 8.
    // The loop runs from the farthest position to the nearest so that the
    // nearest requester is the one left in the result. Returns {found, idx}.
    function automatic logic [3:0] rr_pick(input logic [7:0] req_v,
                                           input logic [2:0] last);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int i = 8; i >= 1; i--) begin
            idx = last + 3'(i);
            res = req_v[idx] ? {1'b1, idx} : res;
        end
        return res;
    endfunction

    state_e     state_q,    state_d;
    logic [7:0] grant_q,    grant_d;
    logic [2:0] sel_q,      sel_d;
    logic       busy_q,     busy_d;
    logic       preempt_q,  preempt_d;
    logic [2:0] last_idx_q, last_idx_d;
    logic [7:0] count_q,    count_d;

    logic [3:0] win_s;
    logic       win_valid_s;
    logic [2:0] win_idx_s;
    logic       owner_req_s;
    logic       others_s;
    logic       expired_s;

    assign win_s       = rr_pick(bus.req, last_idx_q);
    assign win_valid_s = win_s[3];
    assign win_idx_s   = win_s[2:0];
    assign owner_req_s = bus.req[sel_q];
    assign others_s    = |(bus.req & ~(8'b0000_0001 << sel_q));
    assign expired_s   = (count_q == MAX_HOLD_C);

    // State and output registers; reset wins over everything, even mid-grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= 8'h00;
            sel_q      <= 3'd0;
            busy_q     <= 1'b0;
            preempt_q  <= 1'b0;
            last_idx_q <= 3'd7;
            count_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            preempt_q  <= preempt_d;
            last_idx_q <= last_idx_d;
            count_q    <= count_d;
        end
    end

    // Next-state decision: release beats expiry, expiry needs a waiter.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (win_valid_s) begin
                    state_d = ST_OWN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (!owner_req_s) begin
                    state_d = ST_GAP;
                end else if (expired_s && others_s) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_OWN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and the tenure bookkeeping.
    always_comb begin
        grant_d    = grant_q;
        sel_d      = sel_q;
        last_idx_d = last_idx_q;
        count_d    = count_q;
        preempt_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (win_valid_s) begin
                    grant_d    = 8'b0000_0001 << win_idx_s;
                    sel_d      = win_idx_s;
                    last_idx_d = win_idx_s;
                    count_d    = 8'd1;
                end else begin
                    grant_d    = 8'h00;
                    count_d    = 8'd0;
                end
            end
            ST_OWN: begin
                if (!owner_req_s) begin
                    grant_d = 8'h00;
                    count_d = 8'd0;
                end else if (expired_s && others_s) begin
                    grant_d   = 8'h00;
                    count_d   = 8'd0;
                    preempt_d = 1'b1;
                end else if (expired_s) begin
                    count_d = count_q;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            default: begin
                grant_d = 8'h00;
                count_d = 8'd0;
            end
        endcase
        busy_d = |grant_d;
    end

    assign bus.grant   = grant_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;
    assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_port_select_arbiter.sv
// Directed bench for port_select_arbiter with MAX_HOLD = 4.
// Inputs change 1 ns after a rising edge; outputs are read at that moment,
// i.e. they show the state registered by the edge just taken.
module tb_port_select_arbiter;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_pass;

    port_select_arbiter_if bus_if ();

    port_select_arbiter #(.MAX_HOLD(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count one comparison and report it if it differs.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Check the full output set at once.
    task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] s,
                              input logic p);
        check({tag, ".grant"},   32'(bus_if.grant),   32'(g));
        check({tag, ".sel"},     32'(bus_if.sel),     32'(s));
        check({tag, ".busy"},    32'(bus_if.busy),    32'(|g));
        check({tag, ".preempt"}, 32'(bus_if.preempt), 32'(p));
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        bus_if.req = 8'h00;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] g;
        int         k;
        n_checks   = 0;
        n_pass     = 0;
        reset      = 1'b1;
        bus_if.req = 8'h01;

        // 1: reset holds everything off even with a request pending.
        step(); step(); step();
        expect_out("rst", 8'h00, 3'd0, 1'b0);
        reset = 1'b0;
        step();
        expect_out("rst_rel", 8'h01, 3'd0, 1'b0);

        // 2: full contention, each owner exactly 4 cycles then a preempt GAP.
        do_reset();
        bus_if.req = 8'hFF;
        step();
        for (int n = 0; n < 9; n++) begin
            k = n % 8;
            g = 8'h01 << k;
            for (int c = 0; c < 4; c++) begin
                expect_out("rr_own", g, 3'(k), 1'b0);
                step();
            end
            expect_out("rr_gap", 8'h00, 3'(k), 1'b1);
            step();
        end

        // 3: short request, release goes GAP then IDLE with sel parked on 3.
        do_reset();
        bus_if.req = 8'h08;
        step();
        expect_out("rel_own1", 8'h08, 3'd3, 1'b0);
        step();
        expect_out("rel_own2", 8'h08, 3'd3, 1'b0);
        bus_if.req = 8'h00;
        step();
        expect_out("rel_gap", 8'h00, 3'd3, 1'b0);
        step();
        expect_out("rel_idle1", 8'h00, 3'd3, 1'b0);
        step();
        expect_out("rel_idle2", 8'h00, 3'd3, 1'b0);

        // 4: lone owner saturates and keeps the grant, preempted once req[1] rises.
        do_reset();
        bus_if.req = 8'h20;
        for (int c = 0; c < 20; c++) begin
            step();
            expect_out("sat_own", 8'h20, 3'd5, 1'b0);
        end
        bus_if.req = 8'h22;
        step();
        expect_out("sat_gap", 8'h00, 3'd5, 1'b1);
        step();
        expect_out("sat_next", 8'h02, 3'd1, 1'b0);

        // 5: wrap-around from owner 6 to 0 and back to 6.
        do_reset();
        bus_if.req = 8'h40;
        step();
        expect_out("wrap_own6", 8'h40, 3'd6, 1'b0);
        bus_if.req = 8'h01;
        step();
        expect_out("wrap_gap1", 8'h00, 3'd6, 1'b0);
        bus_if.req = 8'h41;
        step();
        expect_out("wrap_own0", 8'h01, 3'd0, 1'b0);
        step(); step(); step();
        expect_out("wrap_own0_last", 8'h01, 3'd0, 1'b0);
        step();
        expect_out("wrap_gap2", 8'h00, 3'd0, 1'b1);
        step();
        expect_out("wrap_own6b", 8'h40, 3'd6, 1'b0);

        // 6: reset mid-grant clears the pointer, so the scan restarts at 0.
        do_reset();
        bus_if.req = 8'h10;
        step();
        step();
        expect_out("mid_own", 8'h10, 3'd4, 1'b0);
        reset = 1'b1;
        step();
        expect_out("mid_rst", 8'h00, 3'd0, 1'b0);
        reset      = 1'b0;
        bus_if.req = 8'h90;
        step();
        expect_out("mid_after", 8'h10, 3'd4, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
